// File: rtl/nios_i2c_acc_timer_sequencer_pkg.sv
// nios_i2c_acc_tseq_pkg: op codes, FSM states, interval-timer register map and control words for the timer sequencer
package nios_i2c_acc_tseq_pkg;
  typedef enum logic [1:0] {
    OP_START_PERIODIC = 2'd0,
    OP_START_ONESHOT  = 2'd1,
    OP_STOP           = 2'd2,
    OP_SNAPSHOT       = 2'd3
  } op_e;
  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTL,
    WR_STOP,
    CLR_ST,
    SNAP_WR,
    SNAP_RDL,
    SNAP_RDH,
    SNAP_CAPH
  } state_e;
  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;
  localparam logic [15:0] CTL_PERIODIC = 16'h0007;
  localparam logic [15:0] CTL_ONESHOT  = 16'h0005;
  localparam logic [15:0] CTL_STOP     = 16'h0008;
endpackage

// File: rtl/nios_i2c_acc_timer_sequencer_if.sv
// nios_i2c_acc_timer_sequencer_if: Avalon-MM master bus to the interval timer (avm_address/chipselect/write_n/writedata out, avm_readdata in; no waitrequest, read data one cycle after address)
interface nios_i2c_acc_timer_sequencer_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata
  );
  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/nios_i2c_acc_timer_sequencer.sv
// nios_i2c_acc_timer_sequencer: sequences interval-timer bus accesses for start/stop/snapshot commands and irq acknowledge (clk, reset, cmd_* handshake, avm master if, timer_irq in; tick/tick_count/running/snapshot/snap_valid/busy out; snapshot path under NIOS_I2C_ACC_TSEQ_SNAPSHOT_EN)
module nios_i2c_acc_timer_sequencer
  import nios_i2c_acc_tseq_pkg::*;
#(
  parameter int TICK_W = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [1:0]                           cmd_op,
  input  logic [31:0]                          cmd_period,
  nios_i2c_acc_timer_sequencer_if.master       avm,
  input  logic                                 timer_irq,
  output logic                                 tick,
  output logic [TICK_W-1:0]                    tick_count,
  output logic                                 running,
  output logic [31:0]                          snapshot,
  output logic                                 snap_valid,
  output logic                                 busy
);
  state_e      state;
  logic [15:0] period_hi;
  logic        oneshot;
  assign cmd_ready = state == IDLE && !timer_irq;
  assign busy      = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      period_hi          <= '0;
      oneshot            <= 1'b0;
      tick               <= 1'b0;
      tick_count         <= '0;
      running            <= 1'b0;
      avm.avm_address    <= '0;
      avm.avm_chipselect <= 1'b0;
      avm.avm_write_n    <= 1'b1;
      avm.avm_writedata  <= '0;
    end else begin
      tick               <= 1'b0;
      avm.avm_address    <= '0;
      avm.avm_chipselect <= 1'b0;
      avm.avm_write_n    <= 1'b1;
      avm.avm_writedata  <= '0;
      case (state)
        IDLE: begin
          if (timer_irq) begin
            state              <= CLR_ST;
            avm.avm_address    <= ADDR_STATUS;
            avm.avm_chipselect <= 1'b1;
            avm.avm_write_n    <= 1'b0;
            tick               <= 1'b1;
            tick_count         <= tick_count + 1'b1;
            if (oneshot) running <= 1'b0;
          end else if (cmd_valid) begin
            case (op_e'(cmd_op))
              OP_START_PERIODIC, OP_START_ONESHOT: begin
                state              <= WR_PL;
                period_hi          <= cmd_period[31:16];
                oneshot            <= cmd_op[0];
                avm.avm_address    <= ADDR_PERIOD_L;
                avm.avm_chipselect <= 1'b1;
                avm.avm_write_n    <= 1'b0;
                avm.avm_writedata  <= cmd_period[15:0];
              end
              OP_STOP: begin
                state              <= WR_STOP;
                running            <= 1'b0;
                avm.avm_address    <= ADDR_CONTROL;
                avm.avm_chipselect <= 1'b1;
                avm.avm_write_n    <= 1'b0;
                avm.avm_writedata  <= CTL_STOP;
              end
              OP_SNAPSHOT: begin
`ifdef NIOS_I2C_ACC_TSEQ_SNAPSHOT_EN
                state              <= SNAP_WR;
                avm.avm_address    <= ADDR_SNAP_L;
                avm.avm_chipselect <= 1'b1;
                avm.avm_write_n    <= 1'b0;
`else
                state              <= IDLE;
`endif
              end
            endcase
          end
        end
        WR_PL: begin
          state              <= WR_PH;
          avm.avm_address    <= ADDR_PERIOD_H;
          avm.avm_chipselect <= 1'b1;
          avm.avm_write_n    <= 1'b0;
          avm.avm_writedata  <= period_hi;
        end
        WR_PH: begin
          state              <= WR_CTL;
          running            <= 1'b1;
          avm.avm_address    <= ADDR_CONTROL;
          avm.avm_chipselect <= 1'b1;
          avm.avm_write_n    <= 1'b0;
          avm.avm_writedata  <= oneshot ? CTL_ONESHOT : CTL_PERIODIC;
        end
`ifdef NIOS_I2C_ACC_TSEQ_SNAPSHOT_EN
        SNAP_WR: begin
          state              <= SNAP_RDL;
          avm.avm_address    <= ADDR_SNAP_L;
          avm.avm_chipselect <= 1'b1;
        end
        SNAP_RDL: begin
          state              <= SNAP_RDH;
          avm.avm_address    <= ADDR_SNAP_H;
          avm.avm_chipselect <= 1'b1;
        end
        SNAP_RDH: state <= SNAP_CAPH;
`endif
        default: state <= IDLE;
      endcase
    end
  end
`ifdef NIOS_I2C_ACC_TSEQ_SNAPSHOT_EN
  logic [31:0] snap_q;
  logic        snap_v;
  assign snapshot   = snap_q;
  assign snap_valid = snap_v;
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q <= '0;
      snap_v <= 1'b0;
    end else begin
      snap_v <= state == SNAP_CAPH;
      if (state == SNAP_RDH) snap_q[15:0] <= avm.avm_readdata;
      if (state == SNAP_CAPH) snap_q[31:16] <= avm.avm_readdata;
    end
  end
`else
  logic unused_readdata;
  assign unused_readdata = ^avm.avm_readdata;
  assign snapshot        = '0;
  assign snap_valid      = 1'b0;
`endif
endmodule
